// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative Booth multiplier.
// Holds the FSM state encoding, default width and the radix-2 Booth op decode.
package mult_pkg;

   localparam int MULT_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // Radix-2 Booth recoding of {q0, q-1}: 01 adds, 10 subtracts, 00/11 skip.
   function automatic logic [1:0] booth_decode(input logic [1:0] pair);
      logic [1:0] op;
      op = BOOTH_NOP;
      if (pair == 2'b01) op = BOOTH_ADD;
      else if (pair == 2'b10) op = BOOTH_SUB;
      return op;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of the multiplicand
// into the upper partial product, then an arithmetic right shift of the accumulator.
module booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEF
) (
   input  logic [2*WIDTH:0] acc_i,
   input  logic [WIDTH-1:0] a_i,
   output logic [2*WIDTH:0] acc_o
);

   logic [WIDTH:0] upper;
   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] sum;

   // The add/sub is done one bit wider than the stored partial product so that
   // subtracting the most negative multiplicand cannot overflow; the extra sign
   // bit becomes the shifted-in MSB.
   always_comb begin
      upper = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
      a_ext = {a_i[WIDTH-1], a_i};
      sum   = upper;
      case (booth_decode(acc_i[1:0]))
         BOOTH_ADD: sum = upper + a_ext;
         BOOTH_SUB: sum = upper - a_ext;
         default:   sum = upper;
      endcase
      acc_o = {sum, acc_i[WIDTH:1]};
   end

endmodule

// File: rtl/booth_mult_unit.sv
// Iterative radix-2 Booth signed multiplier: one step per cycle, done pulse, held result.
// Optional MULT_OVF_FLAG_EN adds an ovf output flagging products that do not fit in WIDTH bits.
module booth_mult_unit
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
`ifdef MULT_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   mult_state_t        state_q, state_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [2*WIDTH:0]   step_acc;
`ifdef MULT_OVF_FLAG_EN
   logic               ovf_q, ovf_d;
`endif

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc_i (acc_q),
      .a_i   (a_q),
      .acc_o (step_acc)
   );

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      a_d      = a_q;
      cnt_d    = cnt_q;
      result_d = result_q;
`ifdef MULT_OVF_FLAG_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CW'(1);
            // Final step: capture straight from the step output so result and
            // ovf are already valid during the done cycle.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = DONE;
               result_d = step_acc[WIDTH:1];
`ifdef MULT_OVF_FLAG_EN
               ovf_d    = ~((&step_acc[2*WIDTH:WIDTH]) | ~(|step_acc[2*WIDTH:WIDTH]));
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         a_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
`ifdef MULT_OVF_FLAG_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
`ifdef MULT_OVF_FLAG_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
`ifdef MULT_OVF_FLAG_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed and random checks of booth_mult_unit: latency, corners, reset, ignored starts.
module tb_booth_mult_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
`ifdef MULT_OVF_FLAG_EN
   logic        ovf;
`endif

   int total = 0;
   int bad   = 0;

   booth_mult_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
`ifdef MULT_OVF_FLAG_EN
      .ovf    (ovf),
`endif
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Launch one op, scramble the inputs, and wait for done. lat counts cycles
   // after the accept edge (first cycle after accept = 1); 0 means timeout.
   task automatic run_op(input logic [31:0] oa, input logic [31:0] ob,
                         input logic [31:0] hold, output int lat,
                         output logic ovl, output logic held_ok);
      a = oa; b = ob; start = 1'b1;
      tick;
      start = 1'b0;
      a = $urandom; b = $urandom;
      lat = 0; ovl = 1'b0; held_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (busy && done) ovl = 1'b1;
         if (done) begin
            lat = k;
            break;
         end
         if (result !== hold) held_ok = 1'b0;
         tick;
      end
   endtask

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] res;
      logic        ov;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int          lat;
      logic        ovl, held_ok;
      int          ndone;
      logic [31:0] prev;
      logic [63:0] p;
      logic [32:0] top;
      logic        exp_ovf;

      vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
      vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
      vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b0};
      vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
      vecs[8] = '{32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
      vecs[9] = '{32'hFFFF_FFFB, 32'h0000_0006, 32'hFFFF_FFE2, 1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) tick;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_result", {32'd0, result}, 64'd0);
`ifdef MULT_OVF_FLAG_EN
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
      rst_n = 1'b1;
      tick;

      // Directed table, each op started right after the previous done.
      prev = 32'd0;
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].va, vecs[i].vb, prev, lat, ovl, held_ok);
         chk($sformatf("dir%0d_lat", i), 64'(lat), 64'd33);
         chk($sformatf("dir%0d_res", i), {32'd0, result}, {32'd0, vecs[i].res});
         chk($sformatf("dir%0d_hold", i), {63'd0, held_ok}, 64'd1);
         chk($sformatf("dir%0d_ovl", i), {63'd0, ovl}, 64'd0);
`ifdef MULT_OVF_FLAG_EN
         chk($sformatf("dir%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ov});
`endif
         prev = vecs[i].res;
         tick;
         chk($sformatf("dir%0d_done_pulse", i), {63'd0, done}, 64'd0);
      end

      // Reset in the middle of an operation.
      a = 32'd7; b = 32'd9; start = 1'b1;
      tick;
      start = 1'b0;
      chk("mid_busy_before", {63'd0, busy}, 64'd1);
      repeat (9) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_done", {63'd0, done}, 64'd0);
      chk("mid_rst_result", {32'd0, result}, 64'd0);
      tick;
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) ndone++;
         tick;
      end
      chk("mid_rst_no_done", 64'(ndone), 64'd0);

      // Starts while busy and in the done cycle must be ignored.
      a = 32'd5; b = 32'd6; start = 1'b1;
      tick;
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         a = 32'(k + 100); b = 32'd3; start = 1'b1;
         if (done) begin
            ndone++;
            break;
         end
         tick;
      end
      chk("ign_done_seen", 64'(ndone), 64'd1);
      chk("ign_result", {32'd0, result}, 64'd30);
      tick;
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) ndone++;
         tick;
      end
      chk("ign_one_done", 64'(ndone), 64'd1);
      chk("ign_result_held", {32'd0, result}, 64'd30);
      chk("ign_idle", {63'd0, busy}, 64'd0);

      // Random pairs against a 64-bit signed product.
      prev = 32'd30;
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) ra = 32'($signed(ra) >>> 20);
         if (i % 4 == 2) rb = 32'($signed(rb) >>> 24);
         p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
         top = p[63:31];
         exp_ovf = !((top == '0) || (top == '1));
         run_op(ra, rb, prev, lat, ovl, held_ok);
         chk("rnd_lat", 64'(lat), 64'd33);
         chk("rnd_res", {32'd0, result}, {32'd0, p[31:0]});
         chk("rnd_ovl", {63'd0, ovl}, 64'd0);
`ifdef MULT_OVF_FLAG_EN
         chk("rnd_ovf", {63'd0, ovf}, {63'd0, exp_ovf});
`else
         if (exp_ovf && result === 32'hx) chk("rnd_x", 64'd1, 64'd0);
`endif
         prev = p[31:0];
         tick;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
